// File: rtl/ws2811_pkg.sv
// ws2811_pkg
//   Shared definitions for the WS2811 frame sequencer: FSM state encoding,
//   GRB word field offsets, colour channel width and a GRB packing helper.
package ws2811_pkg;

  localparam int unsigned COLOR_W   = 8;
  localparam int unsigned WORD_W    = 3 * COLOR_W;

  // Field offsets inside the 24-bit word shifted out as {G,R,B}
  localparam int unsigned GRB_G_LSB = 2 * COLOR_W;
  localparam int unsigned GRB_R_LSB = 1 * COLOR_W;
  localparam int unsigned GRB_B_LSB = 0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_SEND  = 2'd2,
    ST_LATCH = 2'd3
  } state_t;

  function automatic logic [WORD_W-1:0] pack_grb(
    input logic [COLOR_W-1:0] red,
    input logic [COLOR_W-1:0] green,
    input logic [COLOR_W-1:0] blue
  );
    logic [WORD_W-1:0] word;
    word = '0;
    word[GRB_G_LSB +: COLOR_W] = green;
    word[GRB_R_LSB +: COLOR_W] = red;
    word[GRB_B_LSB +: COLOR_W] = blue;
    return word;
  endfunction

endpackage

// File: rtl/ws2811_scale.sv
// ws2811_scale
//   One colour channel through the master fader, purely combinational:
//   scaled = (color * (brightness + 1)) >> 8, computed with a 16-bit product.
//   brightness = 255 passes the channel unchanged, brightness = 0 yields 0.
// Ports:
//   color      in  8  raw channel value
//   brightness in  8  master fader
//   scaled     out 8  faded channel value
module ws2811_scale
  import ws2811_pkg::*;
(
  input  logic [COLOR_W-1:0] color,
  input  logic [7:0]         brightness,
  output logic [COLOR_W-1:0] scaled
);

  logic [8:0]  gain;
  logic [15:0] product;

  always_comb begin
    gain    = {1'b0, brightness} + 9'd1;
    product = {8'd0, color} * {7'd0, gain};
    scaled  = product[15:8];
  end

endmodule

// File: rtl/ws2811_frame_sequencer.sv
// ws2811_frame_sequencer
//   Walks a frame of NUM_LEDS pixels: fetches each colour from an external
//   pixel store, fades it by 'brightness', hands the {G,R,B} word to a
//   serializer, then holds the line idle for LATCH_CYCLES to latch the strip.
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   enable                     run permission
//   frame_start                one-cycle frame request
//   auto_repeat                restart after every latch
//   brightness                 master fader
//   pix_req / pix_addr         fetch request and pixel index
//   pix_valid / pix_red/green/blue   fetched colour
//   tx_valid / tx_data / tx_ready    word handshake to the serializer
//   latch_gap                  high while the latch gap runs
//   frame_busy                 high in every state but IDLE
//   frame_done                 one-cycle pulse at the end of the latch gap
//   frame_count                completed frames, modulo 256
//   fetch_err                  sticky: a fetch timed out
module ws2811_frame_sequencer
  import ws2811_pkg::*;
#(
  parameter int unsigned NUM_LEDS      = 60,
  parameter int unsigned LATCH_CYCLES  = 1500,
  parameter int unsigned FETCH_TIMEOUT = 64
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic                frame_start,
  input  logic                auto_repeat,
  input  logic [7:0]          brightness,
  input  logic                pix_valid,
  input  logic [COLOR_W-1:0]  pix_red,
  input  logic [COLOR_W-1:0]  pix_green,
  input  logic [COLOR_W-1:0]  pix_blue,
  output logic                pix_req,
  output logic [7:0]          pix_addr,
  output logic                tx_valid,
  output logic [WORD_W-1:0]   tx_data,
  input  logic                tx_ready,
  output logic                latch_gap,
  output logic                frame_busy,
  output logic                frame_done,
  output logic [7:0]          frame_count,
  output logic                fetch_err
);

  localparam int unsigned FW = (FETCH_TIMEOUT > 1) ? $clog2(FETCH_TIMEOUT) : 1;
  localparam int unsigned LW = (LATCH_CYCLES  > 1) ? $clog2(LATCH_CYCLES)  : 1;

  localparam logic [7:0]    LAST_ADDR  = 8'(NUM_LEDS - 1);
  localparam logic [FW-1:0] FETCH_LAST = FW'(FETCH_TIMEOUT - 1);
  localparam logic [LW-1:0] LATCH_LAST = LW'(LATCH_CYCLES - 1);

  state_t              state;
  logic                pend;
  logic [FW-1:0]       fetch_cnt;
  logic [LW-1:0]       latch_cnt;

  logic [COLOR_W-1:0]  red_s;
  logic [COLOR_W-1:0]  green_s;
  logic [COLOR_W-1:0]  blue_s;

  ws2811_scale u_scale_r (.color(pix_red),   .brightness(brightness), .scaled(red_s));
  ws2811_scale u_scale_g (.color(pix_green), .brightness(brightness), .scaled(green_s));
  ws2811_scale u_scale_b (.color(pix_blue),  .brightness(brightness), .scaled(blue_s));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      pend        <= 1'b0;
      fetch_cnt   <= '0;
      latch_cnt   <= '0;
      pix_req     <= 1'b0;
      pix_addr    <= '0;
      tx_valid    <= 1'b0;
      tx_data     <= '0;
      latch_gap   <= 1'b0;
      frame_busy  <= 1'b0;
      frame_done  <= 1'b0;
      frame_count <= '0;
      fetch_err   <= 1'b0;
    end else begin
      frame_done <= 1'b0;

      // Requests seen while a frame is in flight collapse into one pending
      // restart; the clears below come later and win when a frame starts.
      if (frame_start && (state != ST_IDLE)) begin
        pend <= 1'b1;
      end

      unique case (state)
        ST_IDLE: begin
          if (enable && (frame_start || pend)) begin
            state      <= ST_FETCH;
            pix_addr   <= '0;
            pix_req    <= 1'b1;
            fetch_cnt  <= '0;
            frame_busy <= 1'b1;
            pend       <= 1'b0;
          end
        end

        // enable is deliberately ignored here so a started fetch always
        // produces a complete word on the line
        ST_FETCH: begin
          if (pix_valid) begin
            tx_data  <= pack_grb(red_s, green_s, blue_s);
            tx_valid <= 1'b1;
            pix_req  <= 1'b0;
            state    <= ST_SEND;
          end else if (fetch_cnt == FETCH_LAST) begin
            tx_data   <= '0;
            tx_valid  <= 1'b1;
            pix_req   <= 1'b0;
            fetch_err <= 1'b1;
            state     <= ST_SEND;
          end else begin
            fetch_cnt <= fetch_cnt + FW'(1);
          end
        end

        ST_SEND: begin
          if (tx_ready) begin
            tx_valid <= 1'b0;
            if ((pix_addr == LAST_ADDR) || !enable) begin
              state     <= ST_LATCH;
              latch_gap <= 1'b1;
              latch_cnt <= '0;
            end else begin
              pix_addr  <= pix_addr + 8'd1;
              pix_req   <= 1'b1;
              fetch_cnt <= '0;
              state     <= ST_FETCH;
            end
          end
        end

        ST_LATCH: begin
          if (latch_cnt == LATCH_LAST) begin
            latch_gap   <= 1'b0;
            frame_done  <= 1'b1;
            frame_count <= frame_count + 8'd1;
            pix_addr    <= '0;
            if (enable && (auto_repeat || pend || frame_start)) begin
              state     <= ST_FETCH;
              pix_req   <= 1'b1;
              fetch_cnt <= '0;
              pend      <= 1'b0;
            end else begin
              state      <= ST_IDLE;
              frame_busy <= 1'b0;
            end
          end else begin
            latch_cnt <= latch_cnt + LW'(1);
          end
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ws2811_frame_sequencer.sv
// tb_ws2811_frame_sequencer
//   Directed self-checking bench for ws2811_frame_sequencer with NUM_LEDS=3,
//   LATCH_CYCLES=1500, FETCH_TIMEOUT=64. A pixel-store responder answers
//   pix_req two cycles later; a monitor logs handshaked words, frame_done
//   cycles and latch-gap run lengths.
module tb_ws2811_frame_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        frame_start;
  logic        auto_repeat;
  logic [7:0]  brightness;
  logic        pix_valid;
  logic [7:0]  pix_red;
  logic [7:0]  pix_green;
  logic [7:0]  pix_blue;
  logic        pix_req;
  logic [7:0]  pix_addr;
  logic        tx_valid;
  logic [23:0] tx_data;
  logic        tx_ready;
  logic        latch_gap;
  logic        frame_busy;
  logic        frame_done;
  logic [7:0]  frame_count;
  logic        fetch_err;

  ws2811_frame_sequencer #(
    .NUM_LEDS(3),
    .LATCH_CYCLES(1500),
    .FETCH_TIMEOUT(64)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .frame_start(frame_start),
    .auto_repeat(auto_repeat), .brightness(brightness), .pix_valid(pix_valid),
    .pix_red(pix_red), .pix_green(pix_green), .pix_blue(pix_blue),
    .pix_req(pix_req), .pix_addr(pix_addr), .tx_valid(tx_valid),
    .tx_data(tx_data), .tx_ready(tx_ready), .latch_gap(latch_gap),
    .frame_busy(frame_busy), .frame_done(frame_done),
    .frame_count(frame_count), .fetch_err(fetch_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Pixel store contents, indexed by pix_addr[1:0]
  logic [7:0] t_red   [0:3];
  logic [7:0] t_green [0:3];
  logic [7:0] t_blue  [0:3];
  logic       resp_en;

  // Responder: pix_valid goes high two cycles after pix_req, for one cycle
  initial begin
    int resp_cnt;
    resp_cnt  = 0;
    pix_valid = 1'b0;
    pix_red   = '0;
    pix_green = '0;
    pix_blue  = '0;
    forever begin
      @(posedge clk);
      #1;
      if (pix_valid) begin
        pix_valid = 1'b0;
        resp_cnt  = 0;
      end else if (resp_en && pix_req) begin
        resp_cnt++;
        if (resp_cnt == 2) begin
          pix_red   = t_red[pix_addr[1:0]];
          pix_green = t_green[pix_addr[1:0]];
          pix_blue  = t_blue[pix_addr[1:0]];
          pix_valid = 1'b1;
        end
      end else begin
        resp_cnt = 0;
      end
    end
  end

  // Monitor
  logic [23:0] word_log [0:255];
  logic [7:0]  addr_log [0:255];
  int word_cnt = 0;
  int done_cnt = 0;
  int gap_run  = 0;
  int last_gap = 0;

  initial begin
    forever begin
      @(negedge clk);
      if (tx_valid && tx_ready) begin
        word_log[word_cnt[7:0]] = tx_data;
        addr_log[word_cnt[7:0]] = pix_addr;
        word_cnt++;
      end
      if (frame_done) done_cnt++;
      if (latch_gap) begin
        gap_run++;
      end else if (gap_run != 0) begin
        last_gap = gap_run;
        gap_run  = 0;
      end
    end
  end

  task automatic pulse_start();
    frame_start = 1'b1;
    @(posedge clk);
    #1;
    frame_start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int target, input int budget);
    int n;
    n = 0;
    while ((done_cnt < target) && (n < budget)) begin
      @(posedge clk);
      #1;
      n++;
    end
    check_eq(tag, 32'(done_cnt >= target), 32'd1);
  endtask

  task automatic wait_addr(input string tag, input logic [7:0] a, input int budget);
    int n;
    n = 0;
    while (!((pix_addr == a) && pix_req) && (n < budget)) begin
      @(posedge clk);
      #1;
      n++;
    end
    check_eq(tag, 32'((pix_addr == a) && pix_req), 32'd1);
  endtask

  function automatic logic [23:0] exp_word(input int i);
    return {t_green[i], t_red[i], t_blue[i]};
  endfunction

  initial begin
    int base_w;
    int base_d;
    int n;
    logic [23:0] held;
    logic [7:0]  held_addr;
    logic        stable;

    reset = 1'b1; enable = 1'b0; frame_start = 1'b0; auto_repeat = 1'b0;
    brightness = 8'd255; tx_ready = 1'b1; resp_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      t_red[i]   = 8'h10 + 8'(i);
      t_green[i] = 8'h20 + 8'(i);
      t_blue[i]  = 8'h30 + 8'(i);
    end

    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_pix_req",    32'(pix_req),     32'd0);
    check_eq("rst_pix_addr",   32'(pix_addr),    32'd0);
    check_eq("rst_tx_valid",   32'(tx_valid),    32'd0);
    check_eq("rst_tx_data",    32'(tx_data),     32'd0);
    check_eq("rst_latch_gap",  32'(latch_gap),   32'd0);
    check_eq("rst_frame_busy", 32'(frame_busy),  32'd0);
    check_eq("rst_frame_done", 32'(frame_done),  32'd0);
    check_eq("rst_frame_cnt",  32'(frame_count), 32'd0);
    check_eq("rst_fetch_err",  32'(fetch_err),   32'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Plain frame: three words in order, 1500-cycle gap, one done pulse
    enable = 1'b1; resp_en = 1'b1;
    base_w = word_cnt; base_d = done_cnt;
    pulse_start();
    check_eq("f1_busy", 32'(frame_busy), 32'd1);
    wait_done("f1_done_wait", base_d + 1, 4000);
    @(posedge clk);
    #1;
    check_eq("f1_words", 32'(word_cnt - base_w), 32'd3);
    for (int i = 0; i < 3; i++) begin
      check_eq($sformatf("f1_word%0d", i), 32'(word_log[8'(base_w + i)]), 32'(exp_word(i)));
      check_eq($sformatf("f1_addr%0d", i), 32'(addr_log[8'(base_w + i)]), 32'(i));
    end
    check_eq("f1_gap_len",   32'(last_gap),          32'd1500);
    check_eq("f1_done_cyc",  32'(done_cnt - base_d), 32'd1);
    check_eq("f1_count",     32'(frame_count),       32'd1);
    check_eq("f1_idle_busy", 32'(frame_busy),        32'd0);
    check_eq("f1_no_err",    32'(fetch_err),         32'd0);

    // Brightness 127 on 80/40/FF
    for (int i = 0; i < 4; i++) begin
      t_red[i] = 8'h80; t_green[i] = 8'h40; t_blue[i] = 8'hFF;
    end
    brightness = 8'd127;
    base_w = word_cnt; base_d = done_cnt;
    pulse_start();
    wait_done("f2_done_wait", base_d + 1, 4000);
    check_eq("f2_word0", 32'(word_log[8'(base_w)]),     32'h0020407F);
    check_eq("f2_word2", 32'(word_log[8'(base_w + 2)]), 32'h0020407F);
    check_eq("f2_count", 32'(frame_count), 32'd2);
    brightness = 8'd255;
    for (int i = 0; i < 4; i++) begin
      t_red[i]   = 8'h10 + 8'(i);
      t_green[i] = 8'h20 + 8'(i);
      t_blue[i]  = 8'h30 + 8'(i);
    end

    // Serializer stall: word and address hold for 10 cycles
    tx_ready = 1'b0;
    base_w = word_cnt; base_d = done_cnt;
    pulse_start();
    n = 0;
    while (!tx_valid && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    check_eq("st_valid", 32'(tx_valid), 32'd1);
    held = tx_data; held_addr = pix_addr; stable = 1'b1;
    repeat (10) begin
      @(posedge clk);
      #1;
      if (tx_data !== held || pix_addr !== held_addr || tx_valid !== 1'b1) stable = 1'b0;
    end
    check_eq("st_stable", 32'(stable),    32'd1);
    check_eq("st_word",   32'(held),      32'(exp_word(0)));
    check_eq("st_addr",   32'(held_addr), 32'd0);
    tx_ready = 1'b1;
    wait_done("st_done_wait", base_d + 1, 4000);
    check_eq("st_words", 32'(word_cnt - base_w), 32'd3);
    check_eq("st_count", 32'(frame_count), 32'd3);

    // enable dropped during the first fetch: one whole word, then latch
    base_w = word_cnt; base_d = done_cnt;
    pulse_start();
    enable = 1'b0;
    wait_done("en_done_wait", base_d + 1, 4000);
    check_eq("en_words", 32'(word_cnt - base_w), 32'd1);
    check_eq("en_word0", 32'(word_log[8'(base_w)]), 32'(exp_word(0)));
    check_eq("en_count", 32'(frame_count), 32'd4);
    enable = 1'b1;

    // Fetch timeout: zero word after 64 cycles, sticky fetch_err
    resp_en = 1'b0;
    base_d = done_cnt;
    pulse_start();
    n = 0;
    while (!tx_valid && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    check_eq("to_latency", 32'(n),         32'd64);
    check_eq("to_data",    32'(tx_data),   32'd0);
    check_eq("to_err",     32'(fetch_err), 32'd1);
    wait_done("to_done_wait", base_d + 1, 4000);
    check_eq("to_err_hold", 32'(fetch_err),   32'd1);
    check_eq("to_count",    32'(frame_count), 32'd5);
    resp_en = 1'b1;

    // Two mid-frame starts collapse into exactly one extra frame
    base_d = done_cnt;
    pulse_start();
    wait_addr("pd_addr1", 8'd1, 200);
    pulse_start();
    repeat (3) @(posedge clk);
    #1;
    pulse_start();
    wait_done("pd_done_wait", base_d + 2, 8000);
    repeat (1700) @(posedge clk);
    #1;
    check_eq("pd_frames",  32'(done_cnt - base_d), 32'd2);
    check_eq("pd_idle",    32'(frame_busy),        32'd0);
    check_eq("pd_count",   32'(frame_count),       32'd7);
    check_eq("pd_err_hold", 32'(fetch_err),        32'd1);

    // Asynchronous reset at pix_addr=2
    base_d = done_cnt;
    pulse_start();
    wait_addr("ar_addr2", 8'd2, 200);
    #2;
    reset = 1'b1;
    #1;
    check_eq("ar_pix_req",    32'(pix_req),     32'd0);
    check_eq("ar_pix_addr",   32'(pix_addr),    32'd0);
    check_eq("ar_tx_valid",   32'(tx_valid),    32'd0);
    check_eq("ar_tx_data",    32'(tx_data),     32'd0);
    check_eq("ar_latch_gap",  32'(latch_gap),   32'd0);
    check_eq("ar_frame_busy", 32'(frame_busy),  32'd0);
    check_eq("ar_frame_cnt",  32'(frame_count), 32'd0);
    check_eq("ar_fetch_err",  32'(fetch_err),   32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (1600) @(posedge clk);
    #1;
    check_eq("ar_no_done", 32'(done_cnt - base_d), 32'd0);
    check_eq("ar_idle",    32'(frame_busy),        32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ws2811_frame_sequencer.md
WS2811_FRAME_SEQUENCER -- requirements
Module: ws2811_frame_sequencer

Interface
REQ-001 The block SHALL have parameter NUM_LEDS, default 60, meaning pixels per frame (1..256).
REQ-002 The block SHALL have parameter LATCH_CYCLES, default 1500, meaning idle-line cycles after the last pixel (>=50 us WS2811 latch).
REQ-003 The block SHALL have parameter FETCH_TIMEOUT, default 64, meaning maximum cycles to wait for pixel data.
REQ-004 The block SHALL have port clk  in  1  single system clock; all logic on its rising edge.
REQ-005 The block SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-006 The block SHALL have ports enable  in  1  run permission; frame_start  in  1  one-cycle frame request; auto_repeat  in  1  restart after every latch.
REQ-007 The block SHALL have ports brightness  in  8  master fader; pix_valid  in  1  colour returned; pix_red/pix_green/pix_blue  in  8 each  colour for pix_addr.
REQ-008 The block SHALL have ports pix_req  out  1  fetch request; pix_addr  out  8  pixel index being fetched.
REQ-009 The block SHALL have ports tx_valid  out  1; tx_data  out  24  {G,R,B} word; tx_ready  in  1  serializer accepts word.
REQ-010 The block SHALL have ports latch_gap  out  1; frame_busy  out  1; frame_done  out  1 (one-cycle pulse); frame_count  out  8; fetch_err  out  1 (sticky).

Function
REQ-011 The FSM SHALL use the states IDLE, FETCH, SEND and LATCH.
REQ-012 IDLE SHALL go to FETCH with pix_addr=0 when enable=1 and (frame_start=1 or pend=1); pend SHALL clear on that transition.
REQ-013 A frame_start arriving outside IDLE SHALL set the one-deep flag pend; repeated starts SHALL collapse into that single flag.
REQ-014 In FETCH, pix_req SHALL be 1 and pix_addr SHALL be stable; the first pix_valid=1 cycle SHALL capture the colour and go to SEND the next cycle.
REQ-015 Each captured channel c SHALL be scaled to (c*(brightness+1))>>8 using a 16-bit product: brightness=255 passes c unchanged, brightness=0 yields 0.
REQ-016 If no pix_valid arrives within FETCH_TIMEOUT cycles of entering FETCH, the block SHALL substitute 24'h000000, set fetch_err, and go to SEND.
REQ-017 In SEND, tx_valid SHALL be 1 and tx_data SHALL be held constant until tx_valid&&tx_ready; the word SHALL NOT change while stalled.
REQ-018 On a SEND handshake: if pix_addr==NUM_LEDS-1 or enable=0, the block SHALL go to LATCH; otherwise pix_addr SHALL increment by 1 and the block SHALL go to FETCH.
REQ-019 Deasserting enable mid-FETCH SHALL NOT abort the fetch; the pixel SHALL be sent, then LATCH entered (no torn word on the line).
REQ-020 In LATCH, latch_gap=1, tx_valid=0, and a counter SHALL run LATCH_CYCLES cycles.
REQ-021 At the end of LATCH, frame_done SHALL pulse for 1 cycle, frame_count SHALL increment modulo 256 (wrap 255->0), and the block SHALL go to FETCH(addr 0) if enable and (auto_repeat or pend), else to IDLE.
REQ-022 frame_busy SHALL be 1 in every state except IDLE.
REQ-023 pix_addr SHALL never exceed NUM_LEDS-1; a NUM_LEDS=1 frame SHALL send exactly one word.

Reset
REQ-024 On reset, the block SHALL immediately enter IDLE with: pix_req=0, pix_addr=0, tx_valid=0, tx_data=0, latch_gap=0, frame_busy=0, frame_done=0, frame_count=0, fetch_err=0, pend=0, and all counters at 0.
REQ-025 Reset asserted mid-frame SHALL abandon the frame with no frame_done pulse.

Structure
REQ-026 A shared package ws2811_pkg SHALL hold the FSM state encoding, the GRB field offsets and the colour width constant (8).
REQ-027 The brightness multiply SHALL be a separate sub-module ws2811_scale (one channel, combinational, instantiated three times).

Verification
REQ-028 NUM_LEDS=3, brightness=255, pix_valid 2 cycles after pix_req, tx_ready always 1 -> the bench SHALL observe 3 words in address order, then latch_gap for exactly 1500 cycles, a frame_done pulse, and frame_count=1.
REQ-029 pix_red=8'h80, pix_green=8'h40, pix_blue=8'hFF with brightness=127 -> tx_data SHALL equal 24'h20407F.
REQ-030 tx_ready held 0 for 10 cycles during SEND -> tx_data SHALL stay stable and pix_addr SHALL NOT advance.
REQ-031 pix_valid never asserted -> after 64 cycles, tx_data SHALL equal 0 and fetch_err SHALL be 1 and stay 1 until reset.
REQ-032 frame_start pulsed twice mid-frame with auto_repeat=0 -> exactly one additional frame SHALL run, then the block SHALL return to IDLE.
REQ-033 reset pulsed while at pix_addr=2 -> all outputs SHALL take reset values asynchronously, with no frame_done pulse.
